// File: rtl/temporal_pkg.sv
// Shared types and default sizes for the N-gram temporal encoder.
// HV_DIMENSION is fixed here at 2000 bits (10 folds of 200).
package temporal_pkg;

    localparam int HV_DIMENSION               = 2000;
    localparam int HV_IDX_WIDTH               = $clog2(HV_DIMENSION);
    localparam int NGRAM_SIZE_DEFAULT         = 3;
    localparam int TE_NUM_FOLDS_DEFAULT       = 10;
    localparam int TE_NUM_FOLDS_WIDTH_DEFAULT = 4;
    localparam int TE_FOLD_WIDTH_DEFAULT      = 200;

    typedef enum logic [1:0] {TE_IDLE, TE_COMPUTE, TE_OUTPUT} te_state_t;

    // Source bit of rho^age for query bit (base + offset): left rotate by age.
    function automatic logic [HV_IDX_WIDTH-1:0] rot_src_index(input int base, input int offset,
                                                               input int age);
        return HV_IDX_WIDTH'((base + offset + HV_DIMENSION - age) % HV_DIMENSION);
    endfunction

endpackage

// File: rtl/temporal_encoder_if.sv
// Input/output hypervector handshake bundle of the temporal encoder.
// The flush signal exists only when TEMPORAL_FLUSH_EN is defined.
interface temporal_encoder_if;
    import temporal_pkg::*;

    // A transfer happens on a rising clk edge where valid && ready. Once valid
    // is raised it stays high with stable data until that edge, and valid is
    // never derived from ready.
    logic                    hvin_valid;
    logic                    hvin_ready;
    logic [HV_DIMENSION-1:0] hvin;
    logic                    hvout_valid;
    logic                    hvout_ready;
    logic [HV_DIMENSION-1:0] hvout;

`ifdef TEMPORAL_FLUSH_EN
    logic                    flush;

    modport slave  (input  hvin_valid, hvin, flush, hvout_ready,
                    output hvin_ready, hvout_valid, hvout);
    modport master (output hvin_valid, hvin, flush, hvout_ready,
                    input  hvin_ready, hvout_valid, hvout);
`else
    modport slave  (input  hvin_valid, hvin, hvout_ready,
                    output hvin_ready, hvout_valid, hvout);
    modport master (output hvin_valid, hvin, hvout_ready,
                    input  hvin_ready, hvout_valid, hvout);
`endif

endinterface

// File: rtl/ngram_fold.sv
// Combinational rotate-and-XOR for one query fold: bit j of fold f is the XOR
// over ages k of h[k][(f*W + j - k) mod HV_DIMENSION].
module ngram_fold
    import temporal_pkg::*;
#(
    parameter int NGRAM_SIZE         = NGRAM_SIZE_DEFAULT,
    parameter int TE_NUM_FOLDS       = TE_NUM_FOLDS_DEFAULT,
    parameter int TE_NUM_FOLDS_WIDTH = TE_NUM_FOLDS_WIDTH_DEFAULT,
    parameter int TE_FOLD_WIDTH      = TE_FOLD_WIDTH_DEFAULT
) (
    input  logic [NGRAM_SIZE-1:0][HV_DIMENSION-1:0] i_hist,
    input  logic [TE_NUM_FOLDS_WIDTH-1:0]           i_fold_counter,
    output logic [TE_FOLD_WIDTH-1:0]                o_fold
);

    int w_base;

    always_comb begin
        w_base = int'(i_fold_counter) * TE_FOLD_WIDTH;
        o_fold = '0;
        if (int'(i_fold_counter) < TE_NUM_FOLDS) begin
            // Source bits may fall in neighbouring folds, so index the full history.
            for (int j = 0; j < TE_FOLD_WIDTH; j++) begin
                for (int k = 0; k < NGRAM_SIZE; k++) begin
                    o_fold[j] = o_fold[j] ^ i_hist[k][rot_src_index(w_base, j, k)];
                end
            end
        end
    end

endmodule

// File: rtl/temporal_encoder.sv
// Fold-serial N-gram temporal encoder: slides a history of NGRAM_SIZE windows and
// emits one rotated-XOR query per full window. Optional flush port: TEMPORAL_FLUSH_EN.
module temporal_encoder
    import temporal_pkg::*;
#(
    parameter int NGRAM_SIZE         = NGRAM_SIZE_DEFAULT,
    parameter int TE_NUM_FOLDS       = TE_NUM_FOLDS_DEFAULT,
    parameter int TE_NUM_FOLDS_WIDTH = TE_NUM_FOLDS_WIDTH_DEFAULT,
    parameter int TE_FOLD_WIDTH      = TE_FOLD_WIDTH_DEFAULT
) (
    input  logic                                clk,
    input  logic                                rst,
    temporal_encoder_if.slave                   te_bus,
    output te_state_t                           o_state,
    output logic [$clog2(NGRAM_SIZE+1)-1:0]     o_fill,
    output logic [TE_NUM_FOLDS_WIDTH-1:0]       o_fold_counter
);

    localparam int FILL_W = $clog2(NGRAM_SIZE + 1);
    localparam logic [TE_NUM_FOLDS_WIDTH-1:0] LAST_FOLD = TE_NUM_FOLDS_WIDTH'(TE_NUM_FOLDS - 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(NGRAM_SIZE);

    te_state_t                              r_state;
    logic [FILL_W-1:0]                      r_fill;
    logic [TE_NUM_FOLDS_WIDTH-1:0]          r_fold_counter;
    logic [NGRAM_SIZE-1:0][HV_DIMENSION-1:0] r_hist;
    logic [HV_DIMENSION-1:0]                r_hvout;
    logic                                   r_hvout_valid;
    logic                                   r_hvin_ready;

    logic                                   w_fire;
    logic                                   w_flush;
    logic                                   w_start;
    logic [FILL_W-1:0]                      w_fill_next;
    logic [TE_FOLD_WIDTH-1:0]               w_fold;
    logic [HV_IDX_WIDTH-1:0]                w_fold_base;

`ifdef TEMPORAL_FLUSH_EN
    assign w_flush = te_bus.flush;
`else
    assign w_flush = 1'b0;
`endif

    assign w_fire      = te_bus.hvin_valid && r_hvin_ready;
    assign w_fold_base = HV_IDX_WIDTH'(int'(r_fold_counter) * TE_FOLD_WIDTH);

    // A flush restarts the sequence; a window accepted on the same edge is its first entry.
    always_comb begin
        w_fill_next = r_fill;
        if (w_fire && (r_fill != FILL_FULL)) begin
            w_fill_next = r_fill + FILL_W'(1);
        end
        if (w_flush) begin
            w_fill_next = w_fire ? FILL_W'(1) : '0;
        end
        w_start = w_fire && (w_fill_next == FILL_FULL);
    end

    ngram_fold #(
        .NGRAM_SIZE         (NGRAM_SIZE),
        .TE_NUM_FOLDS       (TE_NUM_FOLDS),
        .TE_NUM_FOLDS_WIDTH (TE_NUM_FOLDS_WIDTH),
        .TE_FOLD_WIDTH      (TE_FOLD_WIDTH)
    ) u_ngram_fold (
        .i_hist         (r_hist),
        .i_fold_counter (r_fold_counter),
        .o_fold         (w_fold)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= TE_IDLE;
            r_fill         <= '0;
            r_fold_counter <= '0;
            r_hist         <= '0;
            r_hvout        <= '0;
            r_hvout_valid  <= 1'b0;
            r_hvin_ready   <= 1'b1;
        end else begin
            r_fill <= w_fill_next;
            unique case (r_state)
                TE_IDLE: begin
                    if (w_fire) begin
                        r_hist <= {r_hist[NGRAM_SIZE-2:0], te_bus.hvin};
                        if (w_start) begin
                            r_state        <= TE_COMPUTE;
                            r_fold_counter <= '0;
                            r_hvin_ready   <= 1'b0;
                        end
                    end
                end
                TE_COMPUTE: begin
                    r_hvout[w_fold_base +: TE_FOLD_WIDTH] <= w_fold;
                    if (r_fold_counter == LAST_FOLD) begin
                        r_fold_counter <= '0;
                        r_state        <= TE_OUTPUT;
                    end else begin
                        r_fold_counter <= r_fold_counter + TE_NUM_FOLDS_WIDTH'(1);
                    end
                end
                TE_OUTPUT: begin
                    // Valid is raised one cycle after the last fold lands in hvout.
                    if (!r_hvout_valid) begin
                        r_hvout_valid <= 1'b1;
                    end else if (te_bus.hvout_ready) begin
                        r_hvout_valid <= 1'b0;
                        r_hvin_ready  <= 1'b1;
                        r_state       <= TE_IDLE;
                    end
                end
                default: begin
                    r_state <= TE_IDLE;
                end
            endcase
        end
    end

    assign te_bus.hvin_ready  = r_hvin_ready;
    assign te_bus.hvout_valid = r_hvout_valid;
    assign te_bus.hvout       = r_hvout;
    assign o_state            = r_state;
    assign o_fill             = r_fill;
    assign o_fold_counter     = r_fold_counter;

endmodule

// File: tb/tb_temporal_encoder.sv
// Self-checking bench for temporal_encoder: reference N-gram model feeding an
// expected-query queue, scenario tasks run in sequence from one initial block.
module tb_temporal_encoder;
    import temporal_pkg::*;

    localparam int D   = HV_DIMENSION;
    localparam int N   = 3;
    localparam int LAT = 11;

    logic      clk = 1'b0;
    logic      rst = 1'b1;
    te_state_t state;
    logic [1:0] fill;
    logic [3:0] fc;

    temporal_encoder_if te_bus();

    temporal_encoder dut (
        .clk            (clk),
        .rst            (rst),
        .te_bus         (te_bus),
        .o_state        (state),
        .o_fill         (fill),
        .o_fold_counter (fc)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int errors   = 0;
    int fire_cnt = 0;
    bit flush_req = 1'b0;

    logic [D-1:0] exp_q[$];
    logic [D-1:0] m_hist [N];
    int           m_fill;

    always @(posedge clk) begin
        if (!rst && te_bus.hvout_valid && te_bus.hvout_ready) fire_cnt++;
    end

    function automatic logic [D-1:0] rotl(input logic [D-1:0] x, input int k);
        if (k == 0) return x;
        return (x << k) | (x >> (D - k));
    endfunction

    function automatic logic [D-1:0] one_hot(input int n);
        logic [D-1:0] v;
        v = {{(D-1){1'b0}}, 1'b1};
        return v << n;
    endfunction

    function automatic logic [D-1:0] rand_hv();
        logic [D-1:0] v;
        v = '0;
        for (int i = 0; i < (D + 31) / 32; i++) v = (v << 32) | D'($urandom());
        return v;
    endfunction

    function automatic logic [D-1:0] model_query();
        logic [D-1:0] q;
        q = '0;
        for (int k = 0; k < N; k++) q = q ^ rotl(m_hist[k], k);
        return q;
    endfunction

    task automatic model_reset();
        m_fill = 0;
        for (int k = 0; k < N; k++) m_hist[k] = '0;
        exp_q.delete();
    endtask

    task automatic drive_idle();
        te_bus.hvin_valid  = 1'b0;
        te_bus.hvin        = '0;
        te_bus.hvout_ready = 1'b1;
`ifdef TEMPORAL_FLUSH_EN
        te_bus.flush       = 1'b0;
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        drive_idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic accept(input logic [D-1:0] v);
        int n;
        n = 0;
        while (!te_bus.hvin_ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!te_bus.hvin_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout hvin_ready=%0b required 1", te_bus.hvin_ready);
            return;
        end
        te_bus.hvin_valid = 1'b1;
        te_bus.hvin       = v;
`ifdef TEMPORAL_FLUSH_EN
        te_bus.flush      = flush_req;
`endif
        @(posedge clk);
        for (int k = N - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
        m_hist[0] = v;
        if (flush_req) m_fill = 1;
        else if (m_fill < N) m_fill++;
        if (m_fill == N) exp_q.push_back(model_query());
        @(negedge clk);
        drive_idle();
    endtask

    task automatic wait_query(input string name, output logic [D-1:0] got);
        int lat;
        logic [D-1:0] exp;
        lat = 0;
        got = '0;
        while (!te_bus.hvout_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat != LAT) begin
            errors++;
            $display("FAIL %s_latency got %0d edges required %0d", name, lat, LAT);
        end
        if (!te_bus.hvout_valid) return;
        got = te_bus.hvout;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s_unexpected_query hvout=%h", name, got);
        end else begin
            exp = exp_q.pop_front();
            if (got !== exp) begin
                errors++;
                $display("FAIL %s_hvout got %h required %h", name, got, exp);
            end
        end
        if (te_bus.hvout_ready) begin
            @(negedge clk);
            checks++;
            if (te_bus.hvin_ready !== 1'b1 || te_bus.hvout_valid !== 1'b0) begin
                errors++;
                $display("FAIL %s_after_fire hvin_ready=%0b hvout_valid=%0b required 1/0",
                         name, te_bus.hvin_ready, te_bus.hvout_valid);
            end
        end
    endtask

    task automatic expect_quiet(input string name, input int cycles);
        bit seen;
        seen = 1'b0;
        repeat (cycles) begin
            @(negedge clk);
            if (te_bus.hvout_valid) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL %s_quiet hvout_valid=1 required 0", name);
        end
    endtask

    task automatic window(input string name, input logic [D-1:0] v);
        logic [D-1:0] got;
        accept(v);
        if (exp_q.size() > 0) wait_query(name, got);
        else expect_quiet(name, LAT + 3);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (state !== TE_IDLE || fill !== 2'd0 || fc !== 4'd0) begin
            errors++;
            $display("FAIL reset_state state=%0d fill=%0d fc=%0d required 0/0/0", state, fill, fc);
        end
        checks++;
        if (te_bus.hvout !== '0 || te_bus.hvout_valid !== 1'b0 || te_bus.hvin_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_outputs hvout_nz=%0b valid=%0b ready=%0b required 0/0/1",
                     |te_bus.hvout, te_bus.hvout_valid, te_bus.hvin_ready);
        end
    endtask

    task automatic test_fill_query();
        logic [D-1:0] got;
        logic [D-1:0] want;
        window("fill1", one_hot(0));
        window("fill2", one_hot(0));
        accept(one_hot(0));
        wait_query("basic", got);
        want = one_hot(0) | one_hot(1) | one_hot(2);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL basic_bits got %h required %h", got, want);
        end
    endtask

    task automatic test_slide();
        logic [D-1:0] got;
        logic [D-1:0] want;
        accept('0);
        wait_query("slide", got);
        want = one_hot(1) | one_hot(2);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL slide_bits got %h required %h", got, want);
        end
    endtask

    task automatic test_wrap();
        logic [D-1:0] got;
        logic [D-1:0] want;
        do_reset();
        window("wrap1", one_hot(D - 1));
        window("wrap2", one_hot(D - 1));
        accept(one_hot(D - 1));
        wait_query("wrap", got);
        want = one_hot(D - 1) | one_hot(0) | one_hot(1);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL wrap_bits got %h required %h", got, want);
        end
    endtask

    task automatic test_backpressure();
        logic [D-1:0] held;
        logic [D-1:0] exp;
        int lat;
        bit bad;
        do_reset();
        window("bp1", rand_hv());
        window("bp2", rand_hv());
        te_bus.hvout_ready = 1'b0;
        accept(rand_hv());
        te_bus.hvout_ready = 1'b0;
        lat = 0;
        while (!te_bus.hvout_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat != LAT) begin
            errors++;
            $display("FAIL bp_latency got %0d edges required %0d", lat, LAT);
        end
        held = te_bus.hvout;
        exp  = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        checks++;
        if (held !== exp) begin
            errors++;
            $display("FAIL bp_hvout got %h required %h", held, exp);
        end
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            te_bus.hvin_valid = 1'b1;
            te_bus.hvin       = rand_hv();
            @(negedge clk);
            if (te_bus.hvout !== held || te_bus.hvin_ready !== 1'b0 || te_bus.hvout_valid !== 1'b1)
                bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL bp_hold valid=%0b hvin_ready=%0b changed=%0b required 1/0/0",
                     te_bus.hvout_valid, te_bus.hvin_ready, te_bus.hvout !== held);
        end
        te_bus.hvin_valid  = 1'b0;
        te_bus.hvout_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (te_bus.hvin_ready !== 1'b1 || te_bus.hvout_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_release hvin_ready=%0b valid=%0b required 1/0",
                     te_bus.hvin_ready, te_bus.hvout_valid);
        end
        window("bp_after", rand_hv());
    endtask

    task automatic test_reset_mid_compute();
        int n;
        int f0;
        do_reset();
        window("rm1", rand_hv());
        window("rm2", rand_hv());
        accept(rand_hv());
        n = 0;
        while (fc !== 4'd4 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (fc !== 4'd4 || state !== TE_COMPUTE) begin
            errors++;
            $display("FAIL rm_reach_fold4 fc=%0d state=%0d required 4/1", fc, state);
        end
        f0 = fire_cnt;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        checks++;
        if (te_bus.hvout !== '0 || te_bus.hvout_valid !== 1'b0 || fill !== 2'd0 || state !== TE_IDLE) begin
            errors++;
            $display("FAIL rm_state hvout_nz=%0b valid=%0b fill=%0d state=%0d required 0/0/0/0",
                     |te_bus.hvout, te_bus.hvout_valid, fill, state);
        end
        expect_quiet("rm_idle", 4);
        checks++;
        if (fire_cnt != f0) begin
            errors++;
            $display("FAIL rm_no_fire fires=%0d required %0d", fire_cnt, f0);
        end
        window("rm_a1", rand_hv());
        window("rm_a2", rand_hv());
        window("rm_a3", rand_hv());
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) window("b2b", rand_hv());
    endtask

`ifdef TEMPORAL_FLUSH_EN
    task automatic test_flush();
        do_reset();
        for (int i = 0; i < 5; i++) window("pre_flush", rand_hv());
        flush_req = 1'b1;
        accept(rand_hv());
        flush_req = 1'b0;
        checks++;
        if (fill !== 2'd1) begin
            errors++;
            $display("FAIL flush_fill got %0d required 1", fill);
        end
        expect_quiet("flush_accept", LAT + 3);
        window("post_flush2", rand_hv());
        window("post_flush3", rand_hv());
    endtask
`endif

    initial begin
        drive_idle();
        test_reset();
        test_fill_query();
        test_slide();
        test_wrap();
        test_backpressure();
        test_reset_mid_compute();
        test_back_to_back();
`ifdef TEMPORAL_FLUSH_EN
        test_flush();
`endif
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_queries got %0d required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "time limit");
    end

endmodule
